// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
// Shared definitions for the N-channel stream multiplexer:
//   - default channel count and data width
//   - sel_width(): select-bus width, max(1, ceil(log2 N))
//   - mode_e: channel selection mode (manual select or round-robin)
package stream_mux_pkg;

    localparam int STREAM_MUX_N_DEFAULT = 32'sd4;
    localparam int STREAM_MUX_W_DEFAULT = 32'sd8;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

    // A select bus is never narrower than one bit, even for N <= 2.
    function automatic int sel_width(input int n);
        return (n > 32'sd2) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. It grants the first requesting channel
// found when searching upward from ptr, wrapping modulo N.
// Ports:
//   req         in   N     per-channel request
//   ptr         in   SELW  highest-priority channel for this cycle
//   grant       out  N     one-hot grant (all zero when nothing requests)
//   grant_idx   out  SELW  binary index of the granted channel
//   grant_valid out  1     a channel was granted
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N = STREAM_MUX_N_DEFAULT,
    localparam int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_valid
);

    int   cand_s;
    logic found_s;

    // Rotating priority search: visit ptr, ptr+1, ... and take the first request.
    // The modulo keeps the search in range even if ptr ever held a value >= N.
    always_comb begin
        grant       = {N{1'b0}};
        grant_idx   = {SELW{1'b0}};
        found_s     = 1'b0;
        cand_s      = 32'sd0;
        for (int k = 0; k < N; k++) begin
            cand_s = (int'(ptr) + k) % N;
            if (!found_s && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                grant_idx     = SELW'(cand_s);
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        grant_valid = found_s;
    end

endmodule

// File: rtl/stream_mux_n.sv
// stream_mux_n
// N-channel, W-bit stream multiplexer with valid/ready handshakes on every
// input and a one-word registered output stage (full throughput: a word can
// drain and a new one load in the same cycle).
//
// Optional feature macro: STREAM_MUX_RR_EN
//   defined   - mode selects manual (sel) or round-robin arbitration; the
//               rr_arbiter and its priority pointer are built.
//   undefined - manual select only; mode is accepted but ignored.
//
// Ports:
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous reset, active-high
//   in_data    in   N*W   channel c occupies bits [c*W +: W]
//   in_valid   in   N     per-channel valid
//   in_ready   out  N     per-channel ready (only the granted channel may be 1)
//   sel        in   SELW  manual channel select; values >= N grant nothing
//   mode       in   1     0 = manual, 1 = round-robin
//   out_data   out  W     registered output word
//   out_valid  out  1     output word held
//   out_ready  in   1     consumer accepts
//
// In round-robin mode in_ready depends combinationally on in_valid, so
// producers must not derive in_valid from in_ready.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int N = STREAM_MUX_N_DEFAULT,
    parameter int W = STREAM_MUX_W_DEFAULT,
    localparam int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam logic [SELW:0] N_L = (SELW+1)'(N);

    logic            load_en_s;
    logic            xfer_s;
    logic            man_hit_s;
    logic [N-1:0]    man_oh_s;
    logic [N-1:0]    grant_oh_s;
    logic [W-1:0]    sel_word_s;
    logic [W-1:0]    out_data_r;
    logic            out_valid_r;

    // The output register can take a new word when empty or being drained.
    assign load_en_s = !out_valid_r || out_ready;

    // Manual grant: one-hot decode of sel, empty when sel points past N-1.
    always_comb begin
        man_hit_s = ({1'b0, sel} < N_L);
        man_oh_s  = {N{1'b0}};
        for (int c = 0; c < N; c++) begin
            man_oh_s[c] = man_hit_s && (sel == SELW'(c));
        end
    end

`ifdef STREAM_MUX_RR_EN
    logic [SELW-1:0] ptr_r;
    logic [SELW-1:0] ptr_next_s;
    logic [N-1:0]    rr_oh_s;
    logic [SELW-1:0] rr_idx_s;
    logic            rr_hit_s;
    logic            rr_mode_s;

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .req         (in_valid),
        .ptr         (ptr_r),
        .grant       (rr_oh_s),
        .grant_idx   (rr_idx_s),
        .grant_valid (rr_hit_s)
    );

    assign rr_mode_s = (mode_e'(mode) == MODE_RR);

    // Pointer moves just past the channel that was served, wrapping at N-1.
    assign ptr_next_s = (rr_idx_s == SELW'(N - 1)) ? {SELW{1'b0}} : (rr_idx_s + SELW'(1'b1));

    // Grant source selection; the arbiter grants nothing when no channel is valid.
    always_comb begin
        grant_oh_s = {N{1'b0}};
        if (rr_mode_s && rr_hit_s) begin
            grant_oh_s = rr_oh_s;
        end else if (rr_mode_s) begin
            grant_oh_s = {N{1'b0}};
        end else begin
            grant_oh_s = man_oh_s;
        end
    end

    // Round-robin priority pointer; advances only on a round-robin transfer,
    // and is left alone by mode switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {SELW{1'b0}};
        end else if (rr_mode_s && xfer_s) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    logic unused_mode_s;

    // Manual-only build: the mode input has no effect.
    assign unused_mode_s = mode;
    assign grant_oh_s    = man_oh_s;
`endif

    // Ready goes only to the granted channel and only when the output can
    // load; reset forces every ready low so nothing is accepted that cycle.
    always_comb begin
        in_ready = {N{1'b0}};
        if (rst) begin
            in_ready = {N{1'b0}};
        end else if (load_en_s) begin
            in_ready = grant_oh_s;
        end else begin
            in_ready = {N{1'b0}};
        end
    end

    assign xfer_s = |(in_ready & in_valid);

    // AND-OR word mux driven by the one-hot grant.
    always_comb begin
        sel_word_s = {W{1'b0}};
        for (int c = 0; c < N; c++) begin
            sel_word_s = sel_word_s | (in_data[c*W +: W] & {W{grant_oh_s[c]}});
        end
    end

    // Output register: a load wins over a drain, so a simultaneous
    // drain+load replaces the word; a bare drain keeps the stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {W{1'b0}};
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_word_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

endmodule
